// File: rtl/led_cmd_pkg.sv
// Shared encodings and command constants for the LED command controller.
// Blink support is compiled in when LED_CMD_BLINK_EN is defined.
package led_cmd_pkg;

  typedef enum logic [1:0] {
    LED_ON    = 2'd0,
    LED_OFF   = 2'd1,
    LED_BLINK = 2'd2
  } led_state_t;

  typedef enum logic {
    P_IDLE    = 1'b0,
    P_WAIT_CH = 1'b1
  } parser_state_t;

  localparam logic [7:0] CASE_OFFSET  = 8'h20;
  localparam logic [7:0] BLINK_PREFIX = 8'h2A;

endpackage

// File: rtl/led_blink_prescaler.sv
// Free-running blink prescaler: phase toggles every BLINK_DIV cycles.
// Only instantiated when LED_CMD_BLINK_EN is defined.
module led_blink_prescaler #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic Clock,
  input  logic Reset,
  output logic phase
);

  localparam int              CNT_W   = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] count_reg;
  logic             phase_reg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_reg <= '0;
      phase_reg <= 1'b0;
    end else if (count_reg == CNT_MAX) begin
      count_reg <= '0;
      phase_reg <= ~phase_reg;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign phase = phase_reg;

endmodule

// File: rtl/led_cmd_ctrl.sv
// Multi-channel LED controller driven by ASCII command bytes; active-low LED outputs.
// Define LED_CMD_BLINK_EN to add the '*'-prefixed BLINK command and the shared prescaler.
module led_cmd_ctrl
  import led_cmd_pkg::*;
#(
  parameter int         NUM_CH    = 3,
  parameter logic [7:0] CH_CHAR0  = 8'h72,
  parameter int         BLINK_DIV = 25_000_000
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [7:0]        Cmd,
  input  logic              Cmd_Valid,
  output logic [NUM_CH-1:0] LED_n,
  output logic              Cmd_Hit
);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("led_cmd_ctrl: NUM_CH must be 1..8");
  end
  if (BLINK_DIV < 2) begin : g_bad_blink_div
    $error("led_cmd_ctrl: BLINK_DIV must be >= 2");
  end

  led_state_t        state_reg [NUM_CH];
  logic [NUM_CH-1:0] lower_hit;
  logic [NUM_CH-1:0] upper_hit;
  logic [NUM_CH-1:0] set_on;
  logic [NUM_CH-1:0] set_off;
  logic [NUM_CH-1:0] set_blink;
  logic              hit_next;
  logic              phase;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_match
    localparam logic [7:0] LOWER_CHAR = CH_CHAR0 + 8'(gi);
    localparam logic [7:0] UPPER_CHAR = LOWER_CHAR - CASE_OFFSET;
    assign lower_hit[gi] = (Cmd == LOWER_CHAR);
    assign upper_hit[gi] = (Cmd == UPPER_CHAR);
  end

`ifdef LED_CMD_BLINK_EN
  parser_state_t parser_reg;
  parser_state_t parser_next;

  led_blink_prescaler #(
    .BLINK_DIV (BLINK_DIV)
  ) u_prescaler (
    .Clock (Clock),
    .Reset (Reset),
    .phase (phase)
  );

  always_ff @(posedge Clock) begin
    if (Reset) parser_reg <= P_IDLE;
    else       parser_reg <= parser_next;
  end

  // Any valid byte in WAIT_CH ends the prefix; it is consumed, never re-decoded.
  always_comb begin
    parser_next = parser_reg;
    if (Cmd_Valid) begin
      unique case (parser_reg)
        P_IDLE:    if (Cmd == BLINK_PREFIX) parser_next = P_WAIT_CH;
        P_WAIT_CH: parser_next = P_IDLE;
        default:   parser_next = P_IDLE;
      endcase
    end
  end

  always_comb begin
    set_on    = '0;
    set_off   = '0;
    set_blink = '0;
    if (Cmd_Valid) begin
      if (parser_reg == P_IDLE) begin
        set_on  = upper_hit;
        set_off = lower_hit;
      end else begin
        set_blink = lower_hit | upper_hit;
      end
    end
  end
`else
  assign phase = 1'b0;

  always_comb begin
    set_on    = '0;
    set_off   = '0;
    set_blink = '0;
    if (Cmd_Valid) begin
      set_on  = upper_hit;
      set_off = lower_hit;
    end
  end
`endif

  assign hit_next = |(set_on | set_off | set_blink);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    always_ff @(posedge Clock) begin
      if (Reset)              state_reg[gi] <= LED_ON;
      else if (set_blink[gi]) state_reg[gi] <= LED_BLINK;
      else if (set_off[gi])   state_reg[gi] <= LED_OFF;
      else if (set_on[gi])    state_reg[gi] <= LED_ON;
    end

    assign LED_n[gi] = (state_reg[gi] == LED_OFF) |
                       ((state_reg[gi] == LED_BLINK) & phase);
  end

  always_ff @(posedge Clock) begin
    if (Reset) Cmd_Hit <= 1'b0;
    else       Cmd_Hit <= hit_next;
  end

endmodule

// File: tb/tb_led_cmd_ctrl.sv
// Self-checking bench for led_cmd_ctrl: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model (either LED_CMD_BLINK_EN build).
module tb_led_cmd_ctrl;

  localparam int NUM_CH = 3;
  localparam int DIV    = 4;
`ifdef LED_CMD_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic        Clock     = 1'b0;
  logic        Reset     = 1'b1;
  logic [7:0]  Cmd       = 8'h00;
  logic        Cmd_Valid = 1'b0;
  logic [2:0]  LED_n;
  logic        Cmd_Hit;

  int tests = 0;
  int fails = 0;

  led_cmd_ctrl #(
    .NUM_CH    (NUM_CH),
    .CH_CHAR0  (8'h72),
    .BLINK_DIV (DIV)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Cmd       (Cmd),
    .Cmd_Valid (Cmd_Valid),
    .LED_n     (LED_n),
    .Cmd_Hit   (Cmd_Hit)
  );

  always #5 Clock = ~Clock;

  // Model: mode 0=ON 1=OFF 2=BLINK; phase derived from edges since the last reset.
  int m_mode [NUM_CH];
  bit m_wait  = 1'b0;
  int m_edges = 0;
  bit m_hit   = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge Clock) begin
    int lo;
    int up;
    if (Reset) begin
      for (int i = 0; i < NUM_CH; i++) m_mode[i] = 0;
      m_wait  = 1'b0;
      m_edges = 0;
      m_hit   = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_edges++;
      m_hit = 1'b0;
      if (Cmd_Valid) begin
        lo = int'(Cmd) - 'h72;
        up = int'(Cmd) - 'h52;
        if (m_wait) begin
          m_wait = 1'b0;
          if (lo >= 0 && lo < NUM_CH) begin m_mode[lo] = 2; m_hit = 1'b1; end
          else if (up >= 0 && up < NUM_CH) begin m_mode[up] = 2; m_hit = 1'b1; end
        end else if (BLINK_EN && Cmd == 8'h2A) begin
          m_wait = 1'b1;
        end else if (lo >= 0 && lo < NUM_CH) begin
          m_mode[lo] = 1; m_hit = 1'b1;
        end else if (up >= 0 && up < NUM_CH) begin
          m_mode[up] = 0; m_hit = 1'b1;
        end
      end
    end
  end

  function automatic logic [2:0] model_led();
    logic [2:0] v;
    bit ph;
    ph = ((m_edges / DIV) % 2) == 1;
    for (int i = 0; i < NUM_CH; i++)
      v[i] = (m_mode[i] == 1) ? 1'b1 : (m_mode[i] == 2) ? ph : 1'b0;
    return v;
  endfunction

  always @(negedge Clock) begin
    if (m_valid) begin
      tests++;
      if (LED_n !== model_led()) begin
        fails++;
        $display("FAIL model_led_n at %0t: got %b expected %b", $time, LED_n, model_led());
      end
      tests++;
      if (Cmd_Hit !== m_hit) begin
        fails++;
        $display("FAIL model_cmd_hit at %0t: got %b expected %b", $time, Cmd_Hit, m_hit);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] %s ok: %h", name, act);
    end
  endtask

  // Returns on the negedge after the strobe edge, when the result is visible.
  task automatic send(input logic [7:0] b);
    @(negedge Clock);
    Cmd       = b;
    Cmd_Valid = 1'b1;
    @(negedge Clock);
    Cmd_Valid = 1'b0;
    Cmd       = 8'h00;
  endtask

  logic [7:0] pool [10] = '{8'h72, 8'h73, 8'h74, 8'h52, 8'h53, 8'h54, 8'h2A, 8'h78, 8'h41, 8'h2A};

  initial begin
    int toggles;
    int diffs;
    logic prev;

    repeat (2) @(negedge Clock);
    check("reset_led_n", {5'd0, LED_n}, 8'h00);
    check("reset_hit", {7'd0, Cmd_Hit}, 8'h00);
    Reset = 1'b0;

    send(8'h72); check("r_led_n", {5'd0, LED_n}, 8'h01); check("r_hit", {7'd0, Cmd_Hit}, 8'h01);
    send(8'h73); check("s_led_n", {5'd0, LED_n}, 8'h03); check("s_hit", {7'd0, Cmd_Hit}, 8'h01);
    send(8'h52); check("R_led_n", {5'd0, LED_n}, 8'h02); check("R_hit", {7'd0, Cmd_Hit}, 8'h01);
    @(negedge Clock);
    check("hit_one_cycle", {7'd0, Cmd_Hit}, 8'h00);

    Cmd = 8'h72; Cmd_Valid = 1'b0;
    @(negedge Clock);
    check("novalid_led_n", {5'd0, LED_n}, 8'h02);
    check("novalid_hit", {7'd0, Cmd_Hit}, 8'h00);
    send(8'h41);
    check("unrec_led_n", {5'd0, LED_n}, 8'h02);
    check("unrec_hit", {7'd0, Cmd_Hit}, 8'h00);

`ifdef LED_CMD_BLINK_EN
    send(8'h2A);
    check("star_hit", {7'd0, Cmd_Hit}, 8'h00);
    check("star_led_n", {5'd0, LED_n}, 8'h02);
    send(8'h54);
    check("blinkT_hit", {7'd0, Cmd_Hit}, 8'h01);
    check("blinkT_low", {6'd0, LED_n[1:0]}, 8'h02);
    toggles = 0;
    prev = LED_n[2];
    for (int i = 0; i < 16; i++) begin
      @(negedge Clock);
      if (LED_n[2] !== prev) toggles++;
      prev = LED_n[2];
    end
    check("blink_toggles_16cyc", 8'(toggles), 8'd4);
    send(8'h2A);
    send(8'h72);
    check("blinkr_hit", {7'd0, Cmd_Hit}, 8'h01);
    diffs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      if (LED_n[0] !== LED_n[2]) diffs++;
    end
    check("blink_in_phase", 8'(diffs), 8'd0);
    send(8'h54);
    check("T_steady_on", {7'd0, LED_n[2]}, 8'h00);

    send(8'h2A);
    send(8'h78);
    check("abort_hit", {7'd0, Cmd_Hit}, 8'h00);
    check("abort_led_n21", {6'd0, LED_n[2:1]}, 8'h01);
    send(8'h72);
    check("after_abort_r", {7'd0, LED_n[0]}, 8'h01);
    check("after_abort_hit", {7'd0, Cmd_Hit}, 8'h01);
    send(8'h2A);
    @(negedge Clock); Reset = 1'b1;
    @(negedge Clock); Reset = 1'b0;
    check("wait_reset_led_n", {5'd0, LED_n}, 8'h00);
    send(8'h73);
    check("post_reset_s", {5'd0, LED_n}, 8'h02);
    check("post_reset_hit", {7'd0, Cmd_Hit}, 8'h01);
`else
    send(8'h2A);
    check("nb_star_hit", {7'd0, Cmd_Hit}, 8'h00);
    check("nb_star_led_n", {5'd0, LED_n}, 8'h02);
    send(8'h74);
    check("nb_t_led_n", {5'd0, LED_n}, 8'h06);
    check("nb_t_hit", {7'd0, Cmd_Hit}, 8'h01);
`endif

    for (int i = 0; i < 600; i++) begin
      @(negedge Clock);
      Reset     = ($urandom_range(0, 59) == 0);
      Cmd_Valid = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 4) != 0) Cmd = pool[$urandom_range(0, 9)];
      else                           Cmd = 8'($urandom);
    end
    @(negedge Clock);
    Reset = 1'b0; Cmd_Valid = 1'b0;
    repeat (3) @(negedge Clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
